// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: command opcodes and controller states.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'b00,
        OP_RUN_UP   = 2'b01,
        OP_RUN_DOWN = 2'b10,
        OP_SET_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/counter_seq_prescaler.sv
// Step-rate prescaler: tick every div+1 cycles, first tick on the cycle after clear.
module counter_seq_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || count == div) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command sequencer driving an external up/down counter to a target value.
// Optional prescaled stepping is enabled by defining COUNTER_SEQ_PRESCALE_EN.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_dir,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             busy,
    output logic             done
);

    state_e           state;
    state_e           state_nxt;
    op_e              op;
    logic             accept;
    logic             at_target;
    logic             tick;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] load_val;
    logic             dir;

    assign op        = op_e'(cmd_op);
    assign accept    = cmd_valid && cmd_ready;
    assign at_target = (cnt_q == target);

`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [DIV_W-1:0] div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (accept && op == OP_SET_DIV) begin
            div <= cmd_arg[DIV_W-1:0];
        end
    end

    // Held clear outside RUN so the first step lands on the cycle after accept.
    counter_seq_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear(state != ST_RUN),
        .div  (div),
        .tick (tick)
    );
`else
    // No divider: step on every cycle.
    assign tick = (DIV_W > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target   <= '0;
            load_val <= '0;
            dir      <= 1'b1;
        end else if (accept) begin
            case (op)
                OP_LOAD:     load_val <= cmd_arg;
                OP_RUN_UP:   begin target <= cmd_arg; dir <= 1'b1; end
                OP_RUN_DOWN: begin target <= cmd_arg; dir <= 1'b0; end
                default:     ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD:    state_nxt = ST_LOAD;
                        OP_SET_DIV: state_nxt = ST_DONE;
                        default:    state_nxt = ST_RUN;
                    endcase
                end
            end
            ST_LOAD: state_nxt = ST_DONE;
            ST_RUN:  if (at_target || abort) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // cnt_en looks at the live counter value so the step that reaches target is the last.
    always_comb begin
        cmd_ready    = (state == ST_IDLE) && !rst;
        busy         = (state != ST_IDLE);
        cnt_load     = (state == ST_LOAD);
        cnt_en       = (state == ST_RUN) && tick && !at_target && !abort;
        done         = (state == ST_DONE);
        cnt_dir      = dir;
        cnt_load_val = load_val;
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench: per-command timeline model plus a per-cycle compare process.
module tb_counter_seq_ctrl;
    import counter_seq_pkg::*;

    localparam int MAXC = 16384;

    typedef struct packed {
        logic       set;
        logic       en;
        logic       load;
        logic       busy;
        logic       done;
        logic       ready;
        logic       chk_dir;
        logic       dir;
        logic       chk_val;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       abort;
    logic [7:0] cnt_q = 8'h00;
    logic       cnt_en;
    logic       cnt_dir;
    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       busy;
    logic       done;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_tab [MAXC];
    int   pulse_q[$];
    int   load_q[$];
    int   done_q[$];
    logic [7:0] model_q = 8'h00;
    int   model_div = 0;

    counter_seq_ctrl #(.WIDTH(8), .DIV_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .abort       (abort),
        .cnt_q       (cnt_q),
        .cnt_en      (cnt_en),
        .cnt_dir     (cnt_dir),
        .cnt_load    (cnt_load),
        .cnt_load_val(cnt_load_val),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The counter register the sequencer controls; reset never touches it.
    always @(posedge clk) begin
        if (cnt_load)     cnt_q <= cnt_load_val;
        else if (cnt_en)  cnt_q <= cnt_dir ? cnt_q + 8'd1 : cnt_q - 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void plan(input int c, input logic en, input logic load, input logic dn,
                                 input logic chk_dir, input logic dir, input logic chk_val,
                                 input logic [7:0] val);
        exp_t e;
        e = '0;
        e.set = 1'b1; e.busy = 1'b1; e.ready = 1'b0;
        e.en = en; e.load = load; e.done = dn;
        e.chk_dir = chk_dir; e.dir = dir; e.chk_val = chk_val; e.val = val;
        if (c >= 0 && c < MAXC) exp_tab[c] = e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            e = '0;
            e.chk_dir = 1'b1; e.dir = 1'b1; e.chk_val = 1'b1;
        end else if (cyc < MAXC && exp_tab[cyc].set) begin
            e = exp_tab[cyc];
        end else begin
            e = '0;
            e.ready = 1'b1;
        end
        check("cmd_ready", 32'(cmd_ready), 32'(e.ready));
        check("busy",      32'(busy),      32'(e.busy));
        check("done",      32'(done),      32'(e.done));
        check("cnt_en",    32'(cnt_en),    32'(e.en));
        check("cnt_load",  32'(cnt_load),  32'(e.load));
        if (e.chk_dir) check("cnt_dir", 32'(cnt_dir), 32'(e.dir));
        if (e.chk_val) check("cnt_load_val", 32'(cnt_load_val), 32'(e.val));
        if (cnt_en)   pulse_q.push_back(cyc);
        if (cnt_load) load_q.push_back(cyc);
        if (done)     done_q.push_back(cyc);
    end

    // Issues one command, predicts its full output timeline, and walks it to completion.
    task automatic do_cmd(input op_e op, input logic [7:0] arg, input int abort_after,
                          input bit abort_on_accept, input bit abort_late, output int t);
        int         n, k_stop, d, last, last_run, abort_cyc, idx;
        logic       up;
        logic [7:0] v;
        @(posedge clk); #1;
        t = cyc;
        pulse_q.delete(); load_q.delete(); done_q.delete();
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; abort = abort_on_accept;
        v = model_q; d = model_div; abort_cyc = -1; last = t + 1;
        case (op)
            OP_LOAD: begin
                plan(t + 1, 0, 1, 0, 0, 0, 1, arg);
                plan(t + 2, 0, 0, 1, 0, 0, 0, 8'h00);
                last = t + 2;
                model_q = arg;
            end
            OP_SET_DIV: begin
                plan(t + 1, 0, 0, 1, 0, 0, 0, 8'h00);
                last = t + 1;
`ifdef COUNTER_SEQ_PRESCALE_EN
                model_div = int'(arg);
`endif
            end
            default: begin
                up = (op == OP_RUN_UP);
                n = up ? ((int'(arg) - int'(v)) & 255) : ((int'(v) - int'(arg)) & 255);
                k_stop = n;
                if (abort_after >= 0 && abort_after < n) begin
                    k_stop    = abort_after;
                    abort_cyc = t + 1 + k_stop * (d + 1);
                    last_run  = abort_cyc;
                end else begin
                    last_run = (n == 0) ? t + 1 : t + 2 + (n - 1) * (d + 1);
                end
                for (int c = t + 1; c <= last_run; c++) begin
                    idx = c - (t + 1);
                    plan(c, (idx % (d + 1) == 0) && (idx / (d + 1) < k_stop), 0, 0, 1, up, 0, 8'h00);
                end
                plan(last_run + 1, 0, 0, 1, 1, up, 0, 8'h00);
                last = last_run + 1;
                model_q = up ? 8'(int'(v) + k_stop) : 8'(int'(v) - k_stop);
            end
        endcase
        @(posedge clk); #1;
        // Keep offering junk commands while busy; none may be accepted.
        cmd_op = 2'($urandom_range(0, 3)); cmd_arg = 8'($urandom);
        while (cyc <= last) begin
            abort = (cyc == abort_cyc) || (abort_late && cyc == last);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; abort = 1'b0;
        check("cnt_q_end", 32'(cnt_q), 32'(model_q));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         t, steps, ab;
        op_e        op;
        logic [7:0] arg;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00; abort = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_busy",  32'(busy),      32'd0);

        do_cmd(OP_LOAD, 8'h5A, -1, 0, 0, t);
        check("load_pulses",   32'(load_q.size()),  32'd1);
        check("load_lat",      32'(load_q[0] - t),  32'd1);
        check("load_done_lat", 32'(done_q[0] - t),  32'd2);

        do_cmd(OP_LOAD, 8'h10, -1, 0, 0, t);
        do_cmd(OP_RUN_UP, 8'h14, -1, 0, 0, t);
        check("up_pulses",   32'(pulse_q.size()),          32'd4);
        check("up_span",     32'(pulse_q[3] - pulse_q[0]), 32'd3);
        check("up_done_lat", 32'(done_q[0] - t),           32'd6);
        check("up_final",    32'(cnt_q),                   32'h14);

        do_cmd(OP_LOAD, 8'h02, -1, 0, 0, t);
        do_cmd(OP_RUN_DOWN, 8'hFE, -1, 0, 0, t);
        check("wrap_pulses", 32'(pulse_q.size()), 32'd4);
        check("wrap_final",  32'(cnt_q),          32'hFE);

        do_cmd(OP_RUN_UP, 8'hFE, -1, 0, 0, t);
        check("eq_pulses",   32'(pulse_q.size()), 32'd0);
        check("eq_done_lat", 32'(done_q[0] - t),  32'd2);

        do_cmd(OP_SET_DIV, 8'h03, -1, 0, 0, t);
        check("div_done_lat", 32'(done_q[0] - t), 32'd1);
        do_cmd(OP_LOAD, 8'h20, -1, 0, 0, t);
        do_cmd(OP_RUN_UP, 8'h23, -1, 0, 0, t);
        check("div_pulses", 32'(pulse_q.size()), 32'd3);
`ifdef COUNTER_SEQ_PRESCALE_EN
        check("div_gap", 32'(pulse_q[1] - pulse_q[0]), 32'd4);
`else
        check("div_gap", 32'(pulse_q[1] - pulse_q[0]), 32'd1);
`endif

        do_cmd(OP_SET_DIV, 8'h00, -1, 0, 0, t);
        do_cmd(OP_LOAD, 8'h30, -1, 0, 0, t);
        do_cmd(OP_RUN_UP, 8'h38, 2, 0, 0, t);
        check("abort_pulses",   32'(pulse_q.size()),          32'd2);
        check("abort_done_lat", 32'(done_q[0] - pulse_q[1]),  32'd2);
        check("abort_final",    32'(cnt_q),                   32'h32);

        for (int i = 0; i < 60; i++) begin
            op = op_e'($urandom_range(0, 3));
            ab = -1;
            case (op)
                OP_LOAD:    arg = 8'($urandom);
                OP_SET_DIV: arg = 8'($urandom_range(0, 3));
                default: begin
                    steps = $urandom_range(0, 20);
                    arg = (op == OP_RUN_UP) ? 8'(int'(model_q) + steps) : 8'(int'(model_q) - steps);
                    if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, steps);
                end
            endcase
            do_cmd(op, arg, ab, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, t);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Reset in the middle of a RUN_DOWN after two steps.
        do_cmd(OP_SET_DIV, 8'h00, -1, 0, 0, t);
        do_cmd(OP_LOAD, 8'h80, -1, 0, 0, t);
        @(posedge clk); #1;
        t = cyc;
        pulse_q.delete();
        cmd_valid = 1'b1; cmd_op = OP_RUN_DOWN; cmd_arg = 8'h40;
        plan(t + 1, 1, 0, 0, 1, 0, 0, 8'h00);
        plan(t + 2, 1, 0, 0, 1, 0, 0, 8'h00);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_cnt_en", 32'(cnt_en),  32'd0);
        check("rst_busy",   32'(busy),    32'd0);
        check("rst_dir",    32'(cnt_dir), 32'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_div = 0;
        model_q = 8'h7E;
        #1;
        check("rst_release_ready", 32'(cmd_ready),       32'd1);
        check("rst_pulses",        32'(pulse_q.size()),  32'd2);
        check("rst_cnt_kept",      32'(cnt_q),           32'h7E);
        do_cmd(OP_RUN_UP, 8'h81, -1, 0, 0, t);
        check("post_rst_pulses", 32'(pulse_q.size()), 32'd3);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
